pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_skid_stage_if.sv | 32 +++
 rtl/pipe_skid_stage.sv | 102 ++++++++++
 tb/tb_pipe_skid_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipe_skid_stage block.
//   pipe_state_t  : EMPTY / BUSY / FULL state of the two-entry skid stage
//   OCC_*         : occupancy encodings reported on the occupancy port
//   occ_of()      : maps a state to its occupancy encoding
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // no entries held
        ST_BUSY  = 2'd1,   // main holds a payload
        ST_FULL  = 2'd2    // main and skid both hold payloads
    } pipe_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_BUSY  = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    function automatic logic [1:0] occ_of(pipe_state_t s);
        logic [1:0] occ;
        occ = OCC_EMPTY;
        case (s)
            ST_EMPTY: occ = OCC_EMPTY;
            ST_BUSY:  occ = OCC_BUSY;
            ST_FULL:  occ = OCC_FULL;
            default:  occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage_if
// Upstream and downstream valid/ready handshake bundle of pipe_skid_stage.
//   in_valid / in_ready / in_data    : upstream side (producer -> stage)
//   out_valid / out_ready / out_data : downstream side (stage -> consumer)
// Handshake rule for both sides: a payload moves exactly on a cycle where
// valid and ready are both 1 at the rising clock edge. A sender holding valid=1
// keeps its payload stable until it moves; ready may change freely.
// Modports:
//   master : the environment (drives in_*, out_ready)
//   slave  : the stage itself (drives in_ready, out_valid, out_data)
// -----------------------------------------------------------------------------
interface pipe_skid_stage_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
// Two-entry pipeline register (main + skid) that fully decouples in_ready from
// the downstream out_ready/stall path. main is always presented on out_data.
// Ports:
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous, active-low reset
//   bus          : handshake bundle (slave modport), WIDTH must match
//   stall        : freezes the output side, same effect as out_ready=0
//   flush        : discards held entries, overriding every transition
//   occupancy    : held entry count 0..2
//   stall_cycles : saturating count of cycles with a payload blocked
//   dbg_state    : current FSM state
// -----------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_skid_stage_if.slave  bus,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles,
    output pipe_state_t       dbg_state
);

    pipe_state_t      state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic eff_ready;
    logic in_fire;
    logic out_fire;

    // in_ready depends only on registered state plus rst/flush, so the
    // upstream never sees a combinational path from out_ready or stall.
    assign bus.in_ready  = rst & ~flush & (state_q != ST_FULL);
    assign bus.out_valid = rst & ~flush & (state_q != ST_EMPTY);
    assign bus.out_data  = main_q;

    assign eff_ready = bus.out_ready & ~stall;
    assign in_fire   = bus.in_valid & bus.in_ready;
    assign out_fire  = bus.out_valid & eff_ready;

    assign occupancy    = occ_of(state_q);
    assign stall_cycles = stall_cnt_q;
    assign dbg_state    = state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            // out_valid already carries ~flush, so a flush cycle never counts.
            if (bus.out_valid && !eff_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end

            // Flush only resets the state; payload registers keep stale data.
            if (flush) begin
                state_q <= ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (in_fire) begin
                            main_q  <= bus.in_data;
                            state_q <= ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        if (in_fire && out_fire) begin
                            main_q <= bus.in_data;
                        end else if (in_fire) begin
                            skid_q  <= bus.in_data;
                            state_q <= ST_FULL;
                        end else if (out_fire) begin
                            state_q <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        // in_ready is 0 here, so only the drain can happen.
                        if (out_fire) begin
                            main_q  <= skid_q;
                            state_q <= ST_BUSY;
                        end
                    end
                    default: begin
                        state_q <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
// Directed and randomized checks of pipe_skid_stage. A queue of held payloads
// plus a blocked-cycle count serves as the reference model. A second instance
// with CNT_W=3 shares the stimulus to observe counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int W = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    pipe_skid_stage_if #(.WIDTH(W)) dif ();
    pipe_skid_stage_if #(.WIDTH(W)) sif ();

    assign sif.in_valid  = dif.in_valid;
    assign sif.in_data   = dif.in_data;
    assign sif.out_ready = dif.out_ready;

    logic [1:0]  occ;
    logic [31:0] scyc;
    pipe_state_t dbg;
    logic [1:0]  sat_occ;
    logic [2:0]  sat_cyc;
    pipe_state_t sat_dbg;

    pipe_skid_stage #(.WIDTH(W), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(dif), .stall(stall), .flush(flush),
        .occupancy(occ), .stall_cycles(scyc), .dbg_state(dbg)
    );

    pipe_skid_stage #(.WIDTH(W), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .bus(sif), .stall(stall), .flush(flush),
        .occupancy(sat_occ), .stall_cycles(sat_cyc), .dbg_state(sat_dbg)
    );

    // ---------------- reference model ----------------
    logic [W-1:0]    exp_q[$];
    longint unsigned exp_cnt;
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic exp_in_ready();
        return rst && !flush && (exp_q.size() < 2);
    endfunction

    function automatic logic exp_out_valid();
        return rst && !flush && (exp_q.size() > 0);
    endfunction

    function automatic logic [2:0] exp_sat();
        return (exp_cnt > 7) ? 3'd7 : 3'(exp_cnt);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic v, input logic [W-1:0] d,
                          input logic ordy, input logic st, input logic fl);
        dif.in_valid  = v;
        dif.in_data   = d;
        dif.out_ready = ordy;
        stall         = st;
        flush         = fl;
    endtask

    // Advance one clock and apply the model's transfer rules for that edge.
    task automatic step();
        logic         do_in;
        logic         do_out;
        logic         blocked;
        logic [W-1:0] d;
        do_in   = exp_in_ready() && dif.in_valid;
        do_out  = exp_out_valid() && dif.out_ready && !stall;
        blocked = exp_out_valid() && !(dif.out_ready && !stall);
        d       = dif.in_data;
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            exp_cnt = 0;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            if (do_out) void'(exp_q.pop_front());
            if (do_in) exp_q.push_back(d);
            if (blocked && exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        set_in(1'b1, 64'hDEAD, 1'b1, 1'b0, 1'b0);
        step();
        step();
        n_cmp++;
        if (dif.in_ready !== 1'b0 || dif.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 0 0", dif.in_ready, dif.out_valid);
        end
        n_cmp++;
        if (occ !== 2'd0 || scyc !== 32'd0 || dbg !== ST_EMPTY) begin
            n_err++;
            $display("FAIL reset_state: occ=%0d stall_cycles=%0d state=%0d expected 0 0 0", occ, scyc, dbg);
        end
        n_cmp++;
        if (dif.out_data !== 64'd0) begin
            n_err++;
            $display("FAIL reset_data: out_data=%h expected 0", dif.out_data);
        end
        rst = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", dif.in_ready, dif.out_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_in(1'b1, 64'hA5, 1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (dif.out_valid !== 1'b1 || dif.out_data !== 64'hA5 || occ !== 2'd1) begin
            n_err++;
            $display("FAIL single_out: valid=%b data=%h occ=%0d expected 1 a5 1", dif.out_valid, dif.out_data, occ);
        end
        step();
        n_cmp++;
        if (occ !== 2'd0 || dif.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_drain: occ=%0d valid=%b expected 0 0", occ, dif.out_valid);
        end
    endtask

    task automatic test_skid_fill();
        do_reset();
        set_in(1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 64'h2, 1'b0, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (occ !== 2'd2 || dif.in_ready !== 1'b0 || dif.out_data !== 64'h1) begin
            n_err++;
            $display("FAIL skid_full: occ=%0d in_ready=%b data=%h expected 2 0 1", occ, dif.in_ready, dif.out_data);
        end
        set_in(1'b1, 64'h3, 1'b0, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (occ !== 2'd2 || dif.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL skid_reject: occ=%0d in_ready=%b expected 2 0", occ, dif.in_ready);
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (dif.out_valid !== 1'b1 || dif.out_data !== 64'h1) begin
            n_err++;
            $display("FAIL skid_first: valid=%b data=%h expected 1 1", dif.out_valid, dif.out_data);
        end
        step();
        n_cmp++;
        if (dif.out_data !== 64'h2 || dif.in_ready !== 1'b1 || occ !== 2'd1) begin
            n_err++;
            $display("FAIL skid_second: data=%h in_ready=%b occ=%0d expected 2 1 1", dif.out_data, dif.in_ready, occ);
        end
        step();
        n_cmp++;
        if (occ !== 2'd0 || dif.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL skid_empty: occ=%0d valid=%b expected 0 0", occ, dif.out_valid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_in(1'b1, 64'h7, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b0, '0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (dif.out_data !== 64'h7 || occ !== 2'd1 || dif.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold: cycle=%0d data=%h occ=%0d valid=%b expected 7 1 1", i, dif.out_data, occ, dif.out_valid);
            end
        end
        n_cmp++;
        if (scyc !== 32'd5) begin
            n_err++;
            $display("FAIL stall_count: stall_cycles=%0d expected 5", scyc);
        end
        stall = 1'b0;
        step();
        n_cmp++;
        if (occ !== 2'd0 || scyc !== 32'd5) begin
            n_err++;
            $display("FAIL stall_release: occ=%0d stall_cycles=%0d expected 0 5", occ, scyc);
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_in(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 64'h12, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 64'h9, 1'b0, 1'b0, 1'b1);
        #1;
        n_cmp++;
        if (dif.in_ready !== 1'b0 || dif.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_comb: in_ready=%b out_valid=%b expected 0 0", dif.in_ready, dif.out_valid);
        end
        step();
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (occ !== 2'd0 || dif.out_valid !== 1'b0 || scyc !== 32'd1) begin
            n_err++;
            $display("FAIL flush_state: occ=%0d valid=%b stall_cycles=%0d expected 0 0 1", occ, dif.out_valid, scyc);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (dif.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_no_output: cycle=%0d valid=%b data=%h expected valid 0", i, dif.out_valid, dif.out_data);
            end
        end
        // flush and stall together: flush wins
        set_in(1'b1, 64'h21, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b0, '0, 1'b1, 1'b1, 1'b1);
        step();
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (occ !== 2'd0 || scyc !== 32'd1) begin
            n_err++;
            $display("FAIL flush_over_stall: occ=%0d stall_cycles=%0d expected 0 1", occ, scyc);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(1'b1, 64'h55, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        n_cmp++;
        if (sat_cyc !== 3'd7 || sat_dbg !== ST_BUSY || sat_occ !== 2'd1) begin
            n_err++;
            $display("FAIL sat_count: stall_cycles=%0d state=%0d occ=%0d expected 7 1 1", sat_cyc, sat_dbg, sat_occ);
        end
        n_cmp++;
        if (scyc !== 32'd10) begin
            n_err++;
            $display("FAIL sat_wide: stall_cycles=%0d expected 10", scyc);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            set_in(1'b1, 64'(i + 1000), 1'b1, 1'b0, 1'b0);
            step();
            n_cmp++;
            if (dif.out_valid !== 1'b1 || dif.out_data !== 64'(i + 1000) || occ !== 2'd1) begin
                n_err++;
                $display("FAIL stream_word: i=%0d valid=%b data=%0d occ=%0d expected 1 %0d 1", i, dif.out_valid, dif.out_data, occ, i + 1000);
            end
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (occ !== 2'd0 || scyc !== 32'd0) begin
            n_err++;
            $display("FAIL stream_end: occ=%0d stall_cycles=%0d expected 0 0", occ, scyc);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
            set_in(1'(($urandom_range(99) < 65)), {$urandom, $urandom},
                   1'(($urandom_range(99) < 60)), 1'(($urandom_range(99) < 20)),
                   1'(($urandom_range(99) < 5)));
            #1;
            n_cmp++;
            if (dif.in_ready !== exp_in_ready() || dif.out_valid !== exp_out_valid()) begin
                n_err++;
                $display("FAIL rand_handshake: i=%0d in_ready=%b out_valid=%b expected %b %b", i, dif.in_ready, dif.out_valid, exp_in_ready(), exp_out_valid());
            end
            n_cmp++;
            if (occ !== 2'(exp_q.size()) || scyc !== 32'(exp_cnt) || sat_cyc !== exp_sat()) begin
                n_err++;
                $display("FAIL rand_state: i=%0d occ=%0d stall_cycles=%0d sat=%0d expected %0d %0d %0d", i, occ, scyc, sat_cyc, exp_q.size(), exp_cnt, exp_sat());
            end
            if (exp_q.size() > 0) begin
                n_cmp++;
                if (dif.out_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL rand_data: i=%0d out_data=%h expected %h", i, dif.out_data, exp_q[0]);
                end
            end
            step();
        end
        rst = 1'b1;
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        exp_cnt = 0;
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_single();
        test_skid_fill();
        test_stall();
        test_flush();
        test_saturation();
        test_streaming();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
